// File: rtl/seq_shift_add_multiplier_rca_nbit.sv
// ---------------------------------------------------------------------------
// rca_nbit
// Parameterised N-bit combinational ripple-carry adder built from full-adder
// cells. It is the single shared adder that the sequential multiplier reuses
// on every iteration.
//
// Ports:
//   a    [N-1:0]  first addend
//   b    [N-1:0]  second addend
//   cin           carry into bit 0
//   sum  [N-1:0]  N-bit sum
//   cout          carry out of bit N-1
// ---------------------------------------------------------------------------
module rca_nbit #(
   parameter int N = 4
) (
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         cin,
   output logic [N-1:0] sum,
   output logic         cout
);

   logic [N:0] w_carry;

   assign w_carry[0] = cin;

   // One full-adder cell per bit; the carry ripples from bit 0 upwards.
   for (genvar i = 0; i < N; i++) begin : g_fullAdder
      assign sum[i]         = a[i] ^ b[i] ^ w_carry[i];
      assign w_carry[i + 1] = (a[i] & b[i]) | (w_carry[i] & (a[i] ^ b[i]));
   end

   assign cout = w_carry[N];

endmodule

// File: rtl/seq_shift_add_multiplier.sv
// ---------------------------------------------------------------------------
// seq_shift_add_multiplier
// Unsigned N x N sequential shift-and-add multiplier. A single N-bit
// ripple-carry adder is reused for N iterations, one per clock, under the
// control of a three-state FSM (IDLE / RUN / DONE).
//
// Ports:
//   clk           rising-edge clock
//   rst           asynchronous, active-high reset
//   start         request, sampled only in IDLE or DONE
//   multiplicand  [N-1:0]   operand M, captured on the accepting edge
//   multiplier    [N-1:0]   operand Q, captured on the accepting edge
//   busy          high while in RUN
//   done          one-cycle pulse, high while in DONE
//   product       [2N-1:0]  last completed product, held until the next one
// ---------------------------------------------------------------------------
module seq_shift_add_multiplier #(
   parameter int N = 4
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           start,
   input  logic [N-1:0]   multiplicand,
   input  logic [N-1:0]   multiplier,
   output logic           busy,
   output logic           done,
   output logic [2*N-1:0] product
);

   localparam int CW = $clog2(N + 1);

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      DONE = 2'b10
   } state_t;

   state_t           r_state;
   state_t           w_nextState;
   logic [N-1:0]     r_m;
   logic [N-1:0]     r_q;
   logic [N-1:0]     r_a;
   logic [CW-1:0]    r_count;
   logic [2*N-1:0]   r_product;

   logic [N-1:0]     w_addend;
   logic [N-1:0]     w_sum;
   logic             w_cout;
   logic             w_accept;
   logic             w_lastIter;

   // A new request is only honoured when the datapath is free; start seen
   // during RUN is deliberately dropped.
   assign w_accept   = start && (r_state == IDLE || r_state == DONE);
   assign w_lastIter = (r_count == CW'(N - 1));

   // The multiplicand is added only when the current multiplier LSB is set.
   assign w_addend = r_q[0] ? r_m : '0;

   rca_nbit #(
      .N (N)
   ) u_adder (
      .a    (r_a),
      .b    (w_addend),
      .cin  (1'b0),
      .sum  (w_sum),
      .cout (w_cout)
   );

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Next-state logic: RUN lasts exactly N edges, DONE lasts one cycle unless
   // a new request arrives, in which case we go straight back to RUN.
   always_comb begin
      w_nextState = r_state;
      unique case (r_state)
         IDLE:    w_nextState = start ? RUN : IDLE;
         RUN:     w_nextState = w_lastIter ? DONE : RUN;
         DONE:    w_nextState = start ? RUN : IDLE;
         default: w_nextState = IDLE;
      endcase
   end

   // Outputs decode straight from the registered state, so neither busy nor
   // done has a combinational path from start.
   always_comb begin
      busy = 1'b0;
      done = 1'b0;
      unique case (r_state)
         RUN:     busy = 1'b1;
         DONE:    done = 1'b1;
         default: begin
            busy = 1'b0;
            done = 1'b0;
         end
      endcase
   end

   // Datapath: operand capture on acceptance, then one add-and-shift per RUN
   // edge. The adder carry-out becomes the new MSB of A in the same shift,
   // so no separate carry flop is needed to hold it between iterations. The
   // low sum bit migrates into Q, which ends up holding the product's lower
   // half. product is written only on the final iteration so it stays stable
   // for the whole of the following operation.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_m       <= '0;
         r_q       <= '0;
         r_a       <= '0;
         r_count   <= '0;
         r_product <= '0;
      end else if (w_accept) begin
         r_m     <= multiplicand;
         r_q     <= multiplier;
         r_a     <= '0;
         r_count <= '0;
      end else if (r_state == RUN) begin
         r_a     <= {w_cout, w_sum[N-1:1]};
         r_q     <= {w_sum[0], r_q[N-1:1]};
         r_count <= r_count + CW'(1);
         if (w_lastIter) begin
            r_product <= {w_cout, w_sum, r_q[N-1:1]};
         end
      end
   end

   assign product = r_product;

endmodule

// File: tb/tb_seq_shift_add_multiplier.sv
// ---------------------------------------------------------------------------
// tb_seq_shift_add_multiplier
// Scoreboard bench for the sequential multiplier: expected products are
// queued when a request is driven and popped when done is seen.
// ---------------------------------------------------------------------------
module tb_seq_shift_add_multiplier;

   localparam int N = 4;

   logic           clk = 1'b0;
   logic           rst;
   logic           start;
   logic [N-1:0]   multiplicand;
   logic [N-1:0]   multiplier;
   logic           busy;
   logic           done;
   logic [2*N-1:0] product;

   int assertCount = 0;
   int failCount   = 0;

   logic [2*N-1:0] expectedQ[$];

   seq_shift_add_multiplier #(
      .N (N)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .multiplicand (multiplicand),
      .multiplier   (multiplier),
      .busy         (busy),
      .done         (done),
      .product      (product)
   );

   // Free-running clock, rising edges at 5, 15, 25, ...
   always #5 clk = ~clk;

   // Safety net so the run always terminates.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   // Drive one request at a falling edge and queue its expected product.
   // Returns at the next falling edge, i.e. just after the accepting edge.
   task automatic applyStimulus(input logic [N-1:0] m, input logic [N-1:0] q,
                                input bit holdStart);
      multiplicand = m;
      multiplier   = q;
      start        = 1'b1;
      expectedQ.push_back((2*N)'(m) * (2*N)'(q));
      @(negedge clk);
      if (!holdStart) start = 1'b0;
      multiplicand = ~m;
      multiplier   = ~q;
   endtask

   // Wait (bounded) for done; cycles counts falling edges from the call.
   task automatic waitForDone(output int cycles, output bit timedOut);
      cycles   = 0;
      timedOut = 1'b1;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         if (done) begin
            cycles   = i;
            timedOut = 1'b0;
            break;
         end
      end
   endtask

   task automatic popExpected(output logic [2*N-1:0] exp);
      if (expectedQ.size() == 0) exp = 'x;
      else exp = expectedQ.pop_front();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      start = 1'b0;
      multiplicand = '0;
      multiplier = '0;
      @(negedge clk);
      @(negedge clk);
      assertCount++;
      if (busy !== 1'b0) begin
         failCount++;
         $display("[TB] FAIL reset_busy: got %b expected 0", busy);
      end
      assertCount++;
      if (done !== 1'b0) begin
         failCount++;
         $display("[TB] FAIL reset_done: got %b expected 0", done);
      end
      assertCount++;
      if (product !== '0) begin
         failCount++;
         $display("[TB] FAIL reset_product: got %h expected 00", product);
      end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_basic();
      int busyCycles = 0;
      int doneAt = 0;
      logic [2*N-1:0] exp;
      logic [2*N-1:0] held;
      applyStimulus(4'b1010, 4'b0110, 1'b0);
      if (busy) busyCycles++;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         if (done) begin
            doneAt = i;
            break;
         end
         if (busy) busyCycles++;
      end
      assertCount++;
      if (doneAt != N) begin
         failCount++;
         $display("[TB] FAIL basic_latency: done after %0d cycles expected %0d", doneAt, N);
      end
      assertCount++;
      if (busyCycles != N) begin
         failCount++;
         $display("[TB] FAIL basic_busy_cycles: got %0d expected %0d", busyCycles, N);
      end
      assertCount++;
      if (busy !== 1'b0) begin
         failCount++;
         $display("[TB] FAIL basic_busy_in_done: got %b expected 0", busy);
      end
      popExpected(exp);
      assertCount++;
      if (product !== exp) begin
         failCount++;
         $display("[TB] FAIL basic_product: got %h expected %h", product, exp);
      end
      held = exp;
      @(negedge clk);
      assertCount++;
      if (done !== 1'b0) begin
         failCount++;
         $display("[TB] FAIL basic_done_pulse: done still %b one cycle later, expected 0", done);
      end
      assertCount++;
      if (product !== held) begin
         failCount++;
         $display("[TB] FAIL basic_product_hold: got %h expected %h", product, held);
      end
   endtask

   task automatic test_carry();
      int cycles;
      bit timedOut;
      logic [2*N-1:0] exp;
      applyStimulus(4'hF, 4'hF, 1'b0);
      waitForDone(cycles, timedOut);
      popExpected(exp);
      assertCount++;
      if (timedOut || product !== exp) begin
         failCount++;
         $display("[TB] FAIL carry_product: got %h expected %h (timeout=%0d)", product, exp, timedOut);
      end
      @(negedge clk);
   endtask

   task automatic test_zero_hold();
      int cycles;
      bit timedOut;
      bit holdBad = 1'b0;
      logic [2*N-1:0] exp;
      logic [2*N-1:0] held;
      applyStimulus(4'hD, 4'h0, 1'b0);
      waitForDone(cycles, timedOut);
      popExpected(exp);
      assertCount++;
      if (timedOut || product !== exp) begin
         failCount++;
         $display("[TB] FAIL zero_product: got %h expected %h (timeout=%0d)", product, exp, timedOut);
      end
      held = exp;
      @(negedge clk);
      applyStimulus(4'h8, 4'h1, 1'b0);
      timedOut = 1'b1;
      for (int i = 1; i <= 20; i++) begin
         if (busy && product !== held) holdBad = 1'b1;
         @(negedge clk);
         if (done) begin
            timedOut = 1'b0;
            break;
         end
      end
      assertCount++;
      if (holdBad) begin
         failCount++;
         $display("[TB] FAIL zero_hold_while_busy: product moved during RUN, expected %h", held);
      end
      popExpected(exp);
      assertCount++;
      if (timedOut || product !== exp) begin
         failCount++;
         $display("[TB] FAIL small_product: got %h expected %h (timeout=%0d)", product, exp, timedOut);
      end
      @(negedge clk);
   endtask

   task automatic test_back_to_back();
      int cycles;
      bit timedOut;
      logic [2*N-1:0] exp;
      applyStimulus(4'd3, 4'd5, 1'b1);
      multiplicand = 4'd7;
      multiplier   = 4'd9;
      expectedQ.push_back((2*N)'(7 * 9));
      waitForDone(cycles, timedOut);
      popExpected(exp);
      assertCount++;
      if (timedOut || product !== exp) begin
         failCount++;
         $display("[TB] FAIL b2b_first_product: got %h expected %h (timeout=%0d)", product, exp, timedOut);
      end
      waitForDone(cycles, timedOut);
      start = 1'b0;
      assertCount++;
      if (timedOut || cycles != N + 1) begin
         failCount++;
         $display("[TB] FAIL b2b_spacing: done pulses %0d cycles apart expected %0d", cycles, N + 1);
      end
      popExpected(exp);
      assertCount++;
      if (product !== exp) begin
         failCount++;
         $display("[TB] FAIL b2b_second_product: got %h expected %h", product, exp);
      end
      @(negedge clk);
      @(negedge clk);
   endtask

   task automatic test_start_during_run();
      int cycles;
      bit timedOut;
      bit extraActivity = 1'b0;
      logic [2*N-1:0] exp;
      applyStimulus(4'd10, 4'd6, 1'b0);
      @(negedge clk);
      multiplicand = 4'd1;
      multiplier   = 4'd1;
      start        = 1'b1;
      @(negedge clk);
      start = 1'b0;
      waitForDone(cycles, timedOut);
      assertCount++;
      if (timedOut || cycles != N - 2) begin
         failCount++;
         $display("[TB] FAIL run_start_latency: done after %0d more cycles expected %0d", cycles, N - 2);
      end
      popExpected(exp);
      assertCount++;
      if (product !== exp) begin
         failCount++;
         $display("[TB] FAIL run_start_product: got %h expected %h", product, exp);
      end
      for (int i = 0; i < 2 * N; i++) begin
         @(negedge clk);
         if (done || busy) extraActivity = 1'b1;
      end
      assertCount++;
      if (extraActivity) begin
         failCount++;
         $display("[TB] FAIL run_start_ignored: extra busy/done seen, expected none");
      end
   endtask

   task automatic test_reset_mid_run();
      int cycles;
      bit timedOut;
      bit doneSeen = 1'b0;
      logic [2*N-1:0] exp;
      applyStimulus(4'd9, 4'd11, 1'b0);
      @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      void'(expectedQ.pop_front());
      assertCount++;
      if (busy !== 1'b0 || done !== 1'b0 || product !== '0) begin
         failCount++;
         $display("[TB] FAIL midrun_reset: busy=%b done=%b product=%h expected 0 0 00",
                  busy, done, product);
      end
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         if (done) doneSeen = 1'b1;
      end
      rst = 1'b0;
      @(negedge clk);
      if (done) doneSeen = 1'b1;
      assertCount++;
      if (doneSeen) begin
         failCount++;
         $display("[TB] FAIL midrun_no_done: done pulsed after abort, expected 0");
      end
      applyStimulus(4'd4, 4'd4, 1'b0);
      waitForDone(cycles, timedOut);
      popExpected(exp);
      assertCount++;
      if (timedOut || product !== exp) begin
         failCount++;
         $display("[TB] FAIL post_reset_product: got %h expected %h (timeout=%0d)", product, exp, timedOut);
      end
      @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_basic();
      test_carry();
      test_zero_hold();
      test_back_to_back();
      test_start_during_run();
      test_reset_mid_run();
      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
